// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizes, state encoding and request rotation for mux_rr_arbiter
package mux_arb_pkg;
  localparam int N_DEF = 64;
  localparam int S_DEF = 64;
  localparam int SEL_W = $clog2(S_DEF);
  localparam int SP = 2 ** SEL_W;
  localparam int RMAX = 256;
  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;
  // Bit i of the result is request (i + p) mod s, so bit 0 is the highest-priority lane.
  function automatic logic [RMAX-1:0] rotate(input logic [RMAX-1:0] v, input int unsigned p, input int unsigned s);
    rotate = '0;
    for (int i = 0; i < RMAX; i++)
      if (i < s) rotate[i] = v[(i + p) % s];
  endfunction
endpackage

// File: rtl/mux.sv
// mux: N-bit word select from a padded flattened input bus
module mux #(
  parameter int N = 64,
  parameter int S = 64,
  parameter int W = $clog2(S)
) (
  input  logic [(2**W)*N-1:0] data_in,
  input  logic [W-1:0]        sel,
  output logic [N-1:0]        y
);
  // Plain indexed part-select; the arbiter keeps sel below S.
  always_comb y = data_in[int'(sel)*N +: N];
endmodule

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner search by rotate, priority encode, un-rotate
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int S = S_DEF,
  parameter int W = $clog2(S)
) (
  input  logic [S-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [S-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [S-1:0] rot;
  logic [W-1:0] k;
  // The index is taken modulo S so a padded lane can never win.
  always_comb begin
    rot = S'(rotate(RMAX'(req), int'(ptr), S));
    k = '0;
    for (int i = S - 1; i >= 0; i--)
      if (rot[i]) k = W'(i);
    idx = W'((int'(k) + int'(ptr)) % S);
    any = |req;
    onehot = any ? (S'(1) << idx) : '0;
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter driving a shared mux into a valid/ready register (lock burst option: MUX_ARB_LOCK_EN)
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int S = S_DEF,
  localparam int W = $clog2(S),
  localparam int P = 2 ** W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [S-1:0]   req,
`ifdef MUX_ARB_LOCK_EN
  input  logic [S-1:0]   lock,
`endif
  input  logic [P*N-1:0] data_in,
  output logic [S-1:0]   gnt,
  output logic [W-1:0]   sel,
  output logic           out_valid,
  output logic [N-1:0]   out_data,
  input  logic           out_ready
);
  state_t state;
  logic [W-1:0] ptr, idx, nptr;
  logic [S-1:0] onehot;
  logic [N-1:0] mux_y;
  logic any, adv;
  rr_pick #(.S(S), .W(W)) u_pick (.req(req), .ptr(ptr), .onehot(onehot), .idx(idx), .any(any));
  mux #(.N(N), .S(S), .W(W)) u_mux (.data_in(data_in), .sel(idx), .y(mux_y));
  // Grant whenever the output slot is empty or being drained; never while in reset.
  always_comb begin
    adv = (state == IDLE) | out_ready;
    gnt = (adv & rst_n) ? onehot : '0;
`ifdef MUX_ARB_LOCK_EN
    nptr = lock[idx] ? idx : (idx == W'(S - 1)) ? '0 : idx + 1'b1;
`else
    nptr = (idx == W'(S - 1)) ? '0 : idx + 1'b1;
`endif
  end
  // Output register and FSM: load on a grant, empty when drained with nothing pending, hold when stalled.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_data <= '0;
      sel <= '0;
      ptr <= '0;
    end else if (adv) begin
      state <= any ? FULL : IDLE;
      out_valid <= any;
      if (any) begin
        sel <= idx;
        out_data <= mux_y;
        ptr <= nptr;
      end
    end
endmodule
